// File: rtl/button_conditioner.sv
// Push-button input conditioner.
// Each channel turns a raw, asynchronous, bouncing button level into clean
// synchronous events. The stages are a polarity fix, a 2-FF synchroniser, a
// counter debouncer that emits press/release pulses, and a per-channel hold FSM
// that fires a single long-press pulse.
// All outputs come from flops, so nothing on btn_raw reaches an output
// combinationally.

module button_conditioner #(
  parameter int N_BTN       = 4,
  parameter int DB_COUNT    = 50000,
  parameter int LONG_CYCLES = 5000000,
  parameter int ACTIVE_LOW  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_long
);

  localparam int DB_W   = (DB_COUNT > 1) ? $clog2(DB_COUNT) : 1;
  localparam int HOLD_W = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;

  // Last debounce count value; reaching it with a still-differing sample
  // accepts the new level on the following edge.
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_COUNT - 1);

  // The hold counter is armed one step early so that the long pulse appears
  // on the same edge at which the counter would reach LONG_CYCLES-1.
  localparam logic [HOLD_W-1:0] HOLD_ARM  = HOLD_W'(LONG_CYCLES - 2);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HELD = 2'd1,
    ST_LONG = 2'd2
  } hold_state_e;

  // Normalise polarity so that 1 always means "pressed" from here on.
  logic [N_BTN-1:0] pol_w;
  assign pol_w = (ACTIVE_LOW != 0) ? ~btn_raw : btn_raw;

  // Two-stage synchroniser. Only s2 is used downstream.
  logic [N_BTN-1:0] s1_q;
  logic [N_BTN-1:0] s2_q;

  // Synchroniser flops; reset loads "not pressed" so a held button is seen
  // as a fresh press once reset is released.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so that s2 samples
    // the previous s1 value rather than the value written on this same edge.
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= pol_w;
      s2_q <= s1_q;
    end
  end

  for (genvar ch = 0; ch < N_BTN; ch++) begin : g_ch

    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic              level_q, level_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    logic              accept_w;

    hold_state_e       state_q;
    logic [HOLD_W-1:0] hold_q;
    logic              long_q;

    // The synchronised sample disagrees with the accepted level for the last
    // qualifying cycle, so the level flips on this edge.
    assign accept_w = (s2_q[ch] != level_q) && (db_cnt_q == DB_LAST);

    // Debounce next state: count consecutive differing samples. A single
    // sample back at the old level clears the count, which rejects glitches.
    always_comb begin
      // NOTE: every signal gets a default first so that no path through the
      // conditionals leaves it unassigned, which would infer a latch.
      db_cnt_d  = '0;
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      if (s2_q[ch] != level_q) begin
        if (db_cnt_q == DB_LAST) begin
          level_d   = s2_q[ch];
          press_d   = s2_q[ch];
          release_d = ~s2_q[ch];
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
    end

    // Debounce registers. The press and release pulses are registered
    // together with the level, so they line up with its first new cycle.
    always_ff @(posedge clk) begin
      // NOTE: every counter and flag here is control state, so all of them are
      // reset explicitly. Nothing in this block is a data array that could
      // be left unreset.
      if (reset) begin
        db_cnt_q  <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        db_cnt_q  <= db_cnt_d;
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
      end
    end

    // Hold FSM: time an accepted press and emit one long pulse. The counter
    // freezes in LONG, so it never wraps and the pulse never repeats.
    always_ff @(posedge clk) begin
      if (reset) begin
        state_q <= ST_IDLE;
        hold_q  <= '0;
        long_q  <= 1'b0;
      end else begin
        long_q <= 1'b0;
        unique case (state_q)
          ST_IDLE: begin
            if (accept_w && s2_q[ch]) begin
              state_q <= ST_HELD;
              hold_q  <= '0;
            end
          end
          ST_HELD: begin
            if (accept_w && !s2_q[ch]) begin
              state_q <= ST_IDLE;
            end else if (hold_q == HOLD_ARM) begin
              state_q <= ST_LONG;
              hold_q  <= HOLD_LAST;
              long_q  <= 1'b1;
            end else begin
              hold_q <= hold_q + 1'b1;
            end
          end
          ST_LONG: begin
            if (accept_w && !s2_q[ch]) begin
              state_q <= ST_IDLE;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
          end
        endcase
      end
    end

    assign btn_level[ch]   = level_q;
    assign btn_press[ch]   = press_q;
    assign btn_release[ch] = release_q;
    assign btn_long[ch]    = long_q;

  end : g_ch

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DB_COUNT=4 and LONG_CYCLES=20.
// Each step drives the inputs, waits for one rising edge, then samples the
// outputs 1 ns later. An input change applied on step k shows up on the
// outputs at step k+5.

module tb_button_conditioner;

  localparam int N_BTN       = 4;
  localparam int DB_COUNT    = 4;
  localparam int LONG_CYCLES = 20;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [N_BTN-1:0] btn_raw = '0;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
  logic [N_BTN-1:0] btn_long;

  int checks = 0;
  int errors = 0;

  // Event bookkeeping for the hand-written sequences: counts and last step.
  int n_prs, n_rel, n_lng, n_both;
  int t_prs, t_rel, t_lng;

  typedef struct {
    logic       rst;
    logic [3:0] raw;
    logic [3:0] lvl;
    logic [3:0] prs;
    logic [3:0] rel;
    logic [3:0] lng;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  button_conditioner #(
    .N_BTN      (N_BTN),
    .DB_COUNT   (DB_COUNT),
    .LONG_CYCLES(LONG_CYCLES),
    .ACTIVE_LOW (0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_long   (btn_long)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycle(input logic rst, input logic [3:0] raw);
    reset   = rst;
    btn_raw = raw;
    @(posedge clk);
    #1;
  endtask

  function automatic void push(input int n, input logic rst, input logic [3:0] raw,
                               input logic [3:0] lvl, input logic [3:0] prs,
                               input logic [3:0] rel, input logic [3:0] lng);
    for (int i = 0; i < n; i++) vecs.push_back('{rst, raw, lvl, prs, rel, lng});
  endfunction

  task automatic clear_ev();
    n_prs = 0; n_rel = 0; n_lng = 0; n_both = 0;
    t_prs = -1; t_rel = -1; t_lng = -1;
  endtask

  task automatic observe(input int ch, input int s);
    if (btn_press[ch])   begin n_prs++; t_prs = s; end
    if (btn_release[ch]) begin n_rel++; t_rel = s; end
    if (btn_long[ch])    begin n_lng++; t_lng = s; end
    if (btn_press[ch] && btn_release[ch]) n_both++;
  endtask

  initial begin
    // Table: reset with all buttons held, fresh press, release, clean ch0
    // press, a 3-cycle ch2 glitch that just misses acceptance, ch0 release.
    //   n  rst raw    lvl    prs    rel    lng
    push(3, 1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0);
    push(5, 0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0);
    push(1, 0, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0);
    push(1, 0, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0);
    push(5, 0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0);
    push(1, 0, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0);
    push(1, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    push(5, 0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0);
    push(1, 0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0);
    push(1, 0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0);
    push(3, 0, 4'h5, 4'h1, 4'h0, 4'h0, 4'h0);
    push(5, 0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0);
    push(5, 0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0);
    push(1, 0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0);
    push(2, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i].rst, vecs[i].raw);
      check($sformatf("vec%0d level", i),   32'(btn_level),   32'(vecs[i].lvl));
      check($sformatf("vec%0d press", i),   32'(btn_press),   32'(vecs[i].prs));
      check($sformatf("vec%0d release", i), 32'(btn_release), 32'(vecs[i].rel));
      check($sformatf("vec%0d long", i),    32'(btn_long),    32'(vecs[i].lng));
    end

    // Bounce on ch1: 1,0,1,0 then steady 1 from step 4, so the press lands at step 9.
    clear_ev();
    for (int s = 0; s < 16; s++) begin
      cycle(1'b0, (s < 4 && (s % 2) == 1) ? 4'h0 : 4'h2);
      observe(1, s);
    end
    check("bounce press count", n_prs, 1);
    check("bounce press step", t_prs, 9);
    check("bounce no release", n_rel, 0);
    check("bounce level", 32'(btn_level), 32'h2);
    for (int s = 16; s < 24; s++) begin
      cycle(1'b0, 4'h0);
      observe(1, s);
    end
    check("bounce release step", t_rel, 21);
    check("bounce release count", n_rel, 1);
    check("bounce no long", n_lng, 0);
    check("bounce no both", n_both, 0);

    // Long press on ch3: press at step 5, long pulse 19 cycles later, release
    // 5 steps after the raw line falls at step 35.
    clear_ev();
    for (int s = 0; s < 45; s++) begin
      cycle(1'b0, (s < 35) ? 4'h8 : 4'h0);
      observe(3, s);
      if (s == 30) check("long level held", 32'(btn_level), 32'h8);
    end
    check("long press step", t_prs, 5);
    check("long pulse count", n_lng, 1);
    check("long pulse step", t_lng, 24);
    check("long release count", n_rel, 1);
    check("long release step", t_rel, 40);

    // Short hold on ch3: 15 accepted cycles, fewer than the 19 needed for long.
    clear_ev();
    for (int s = 0; s < 25; s++) begin
      cycle(1'b0, (s < 15) ? 4'h8 : 4'h0);
      observe(3, s);
    end
    check("short press count", n_prs, 1);
    check("short no long", n_lng, 0);
    check("short release step", t_rel, 20);

    // Mid-operation reset: ch0 reaches LONG and ch1 is mid-debounce when
    // reset hits.
    clear_ev();
    for (int s = 0; s < 29; s++) begin
      cycle(1'b0, (s >= 26) ? 4'h3 : 4'h1);
      observe(0, s);
    end
    check("pre-reset long step", t_lng, 24);
    cycle(1'b1, 4'h3);
    check("reset level", 32'(btn_level), 32'h0);
    check("reset press", 32'(btn_press), 32'h0);
    check("reset release", 32'(btn_release), 32'h0);
    check("reset long", 32'(btn_long), 32'h0);
    clear_ev();
    for (int s = 30; s < 57; s++) begin
      cycle(1'b0, 4'h3);
      observe(0, s);
      if (s < 35)
        check($sformatf("post-reset quiet s%0d", s),
              {btn_level, btn_press, btn_release, btn_long}, 32'h0);
      if (s == 35) begin
        check("post-reset press", 32'(btn_press), 32'h3);
        check("post-reset level", 32'(btn_level), 32'h3);
      end
    end
    check("post-reset no release", n_rel, 0);
    check("post-reset long count", n_lng, 1);
    check("post-reset long step", t_lng, 54);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
